// File: rtl/edge_detect_core.sv
// Edge detector with a configurable input synchronizer.
// Registered rise, fall and mode-selected flag pulses.
module edge_detect_core #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic din,
  output logic flag,
  output logic rise,
  output logic fall
);

  localparam int NS = (SYNC_STAGES < 1) ? 1 :
                      (SYNC_STAGES > 4) ? 4 :
                      SYNC_STAGES;

  logic [NS-1:0] sync_q;
  logic [NS-1:0] sync_d;
  logic          prev_q;
  logic          rise_q;
  logic          fall_q;
  logic          flag_q;
  logic          sync_last;
  logic          rise_d;
  logic          fall_d;
  logic          flag_d;

  // shift the raw level one stage deeper each cycle
  always_comb begin
    sync_d    = '0;
    sync_d[0] = din;
    for (int i = 1; i < NS; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_last = sync_q[NS-1];
  assign rise_d    = sync_last & ~prev_q;
  assign fall_d    = ~sync_last & prev_q;

  // pick the edge kind that drives flag; unknown modes mean both
  always_comb begin
    flag_d = rise_d | fall_d;
    if (EDGE_MODE == 0) begin
      flag_d = rise_d;
    end else if (EDGE_MODE == 1) begin
      flag_d = fall_d;
    end
  end

  // reset clears history too, so pending pulses are dropped
  always_ff @(posedge clock) begin
    if (rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_last;
      rise_q <= rise_d;
      fall_q <= fall_d;
      flag_q <= flag_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
  assign flag = flag_q;

endmodule

// File: tb/tb_edge_detect_core.sv
// Directed bench for edge_detect_core.
// A latency scoreboard predicts every output on every edge.
module tb_edge_detect_core;

  logic clk;
  logic rst;
  logic din;

  logic d_flag, d_rise, d_fall;
  logic m0_flag, m0_rise, m0_fall;
  logic m1_flag, m1_rise, m1_fall;
  logic m3_flag, m3_rise, m3_fall;
  logic s1_flag, s1_rise, s1_fall;

  int checks = 0;
  int errors = 0;
  int cnt_flag = 0;
  int cnt_rise = 0;
  int cnt_fall = 0;
  int cnt_s1 = 0;

  edge_detect_core #(.SYNC_STAGES(2), .EDGE_MODE(2)) u_def (
    .clock(clk), .rst_n(rst), .din(din),
    .flag(d_flag), .rise(d_rise), .fall(d_fall));

  edge_detect_core #(.SYNC_STAGES(2), .EDGE_MODE(0)) u_m0 (
    .clock(clk), .rst_n(rst), .din(din),
    .flag(m0_flag), .rise(m0_rise), .fall(m0_fall));

  edge_detect_core #(.SYNC_STAGES(2), .EDGE_MODE(1)) u_m1 (
    .clock(clk), .rst_n(rst), .din(din),
    .flag(m1_flag), .rise(m1_rise), .fall(m1_fall));

  edge_detect_core #(.SYNC_STAGES(2), .EDGE_MODE(3)) u_m3 (
    .clock(clk), .rst_n(rst), .din(din),
    .flag(m3_flag), .rise(m3_rise), .fall(m3_fall));

  edge_detect_core #(.SYNC_STAGES(1), .EDGE_MODE(2)) u_s1 (
    .clock(clk), .rst_n(rst), .din(din),
    .flag(s1_flag), .rise(s1_rise), .fall(s1_fall));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic r;
    logic f;
  } ev_t;

  ev_t  q2[$];
  ev_t  q1[$];
  logic last2 = 1'b0;
  logic last1 = 1'b0;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int mode, input ev_t e);
    if (mode == 0) return e.r;
    if (mode == 1) return e.f;
    return e.r | e.f;
  endfunction

  task automatic chk_inst(input string n, input int mode,
                          input ev_t e, input logic fl,
                          input logic ri, input logic fa);
    chk({n, ".rise"}, ri, e.r);
    chk({n, ".fall"}, fa, e.f);
    chk({n, ".flag"}, fl, sel(mode, e));
    chk({n, ".excl"}, ri & fa, 1'b0);
  endtask

  // scoreboard: push the edge seen at each sample, pop after the
  // synchronizer latency; reset wipes history and pending events
  always @(posedge clk) begin
    ev_t e2;
    ev_t e1;
    if (rst) begin
      q2.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) q2.push_back('0);
      q1.push_back('0);
      last2 = 1'b0;
      last1 = 1'b0;
      e2 = '0;
      e1 = '0;
    end else begin
      q2.push_back({din & ~last2, ~din & last2});
      q1.push_back({din & ~last1, ~din & last1});
      last2 = din;
      last1 = din;
      e2 = q2.pop_front();
      e1 = q1.pop_front();
    end
    #1;
    chk_inst("def", 2, e2, d_flag, d_rise, d_fall);
    chk_inst("m0", 0, e2, m0_flag, m0_rise, m0_fall);
    chk_inst("m1", 1, e2, m1_flag, m1_rise, m1_fall);
    chk_inst("m3", 3, e2, m3_flag, m3_rise, m3_fall);
    chk_inst("s1", 2, e1, s1_flag, s1_rise, s1_fall);
    cnt_flag += int'(d_flag);
    cnt_rise += int'(d_rise);
    cnt_fall += int'(d_fall);
    cnt_s1   += int'(s1_flag);
  end

  initial begin
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single rise, then single fall
    cnt_flag = 0; cnt_rise = 0; cnt_fall = 0;
    din = 1'b1;
    repeat (6) @(negedge clk);
    chk_int("rise_cnt", cnt_rise, 1);
    chk_int("rise_fall_cnt", cnt_fall, 0);
    din = 1'b0;
    repeat (5) @(negedge clk);
    chk_int("fall_cnt", cnt_fall, 1);
    chk_int("flag_cnt2", cnt_flag, 2);

    // off-grid toggles at 27 ns spacing
    cnt_flag = 0; cnt_rise = 0; cnt_fall = 0;
    for (int i = 0; i < 5; i++) begin
      #27 din = ~din;
    end
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk_int("tog_flag", cnt_flag, 5);
    chk_int("tog_rise", cnt_rise, 3);
    chk_int("tog_fall", cnt_fall, 2);
    din = 1'b0;
    repeat (5) @(negedge clk);

    // reset lands on the edge the pulse would appear
    cnt_flag = 0;
    din = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_int("rst_cancel", cnt_flag, 0);
    din = 1'b1;
    repeat (5) @(negedge clk);
    chk_int("post_rst_edge", cnt_flag, 1);

    // level held high through reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cnt_flag = 0; cnt_rise = 0; cnt_fall = 0;
    repeat (8) @(negedge clk);
    chk_int("held_rise", cnt_rise, 1);
    chk_int("held_flag", cnt_flag, 1);
    chk_int("held_fall", cnt_fall, 0);

    // glitch no edge samples, then one sampled by one edge
    din = 1'b0;
    repeat (5) @(negedge clk);
    cnt_s1 = 0;
    #3 din = 1'b1;
    #4 din = 1'b0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk_int("glitch_none", cnt_s1, 0);
    din = 1'b1;
    @(negedge clk);
    din = 1'b0;
    repeat (4) @(negedge clk);
    chk_int("glitch_one", cnt_s1, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detect_core.md
EDGE_DETECT_CORE -- requirements
Module: edge_detect

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, which sets the number of input synchronizer flops (legal range 1..4).
REQ-002 The block SHALL have parameter EDGE_MODE, default 2, which selects what drives flag: 0 = rising edges, 1 = falling edges, 2 = both edges.
REQ-003 The block SHALL have port clock, input, 1 bit; it is the single clock and all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; it is the reset and SHALL be synchronous and active-high (asserted when 1), despite its name.
REQ-005 The block SHALL have port din, input, 1 bit; it is the monitored level, asynchronous to clock.
REQ-006 The block SHALL have port flag, output, 1 bit; it is a registered one-cycle pulse for each edge selected by EDGE_MODE.
REQ-007 The block SHALL have port rise, output, 1 bit; it is a registered one-cycle pulse on every rising edge of din, regardless of EDGE_MODE.
REQ-008 The block SHALL have port fall, output, 1 bit; it is a registered one-cycle pulse on every falling edge of din, regardless of EDGE_MODE.

Function
REQ-009 din SHALL pass through a chain of SYNC_STAGES flops, sync[0] to sync[SYNC_STAGES-1], before any edge comparison.
REQ-010 A history register prev SHALL hold the value of sync[SYNC_STAGES-1] from the previous cycle.
REQ-011 On each clock edge the block SHALL set rise <= sync_last & ~prev, fall <= ~sync_last & prev, and prev <= sync_last, where sync_last is sync[SYNC_STAGES-1].
REQ-012 flag SHALL be registered as follows: rise term for EDGE_MODE 0, fall term for EDGE_MODE 1, (rise term | fall term) for EDGE_MODE 2.
REQ-013 Latency: if k is the first clock edge at which the new din level is sampled, the pulse SHALL be high from clock edge k+SYNC_STAGES until edge k+SYNC_STAGES+1 (2-cycle latency at default).
REQ-014 Each detected edge SHALL produce exactly one high cycle on the matching output(s); a stable din SHALL keep all outputs low.
REQ-015 If din toggles on every clock edge, the matching outputs SHALL be high on consecutive cycles, one per edge, with no pulse dropped or merged into a count error.
REQ-016 A din glitch that is not sampled by any clock edge SHALL produce no pulse; a glitch sampled by one edge SHALL produce one rise and one fall pulse, one cycle apart.
REQ-017 rise and fall SHALL never be high in the same cycle.
REQ-018 An EDGE_MODE value outside 0..2 SHALL behave as mode 2.

Reset
REQ-019 While rst_n = 1 at a clock edge, the block SHALL clear all sync flops, prev, flag, rise and fall to 0.
REQ-020 Asserting reset mid-operation SHALL cancel any pending or in-progress pulse; outputs SHALL be 0 from the first edge where reset is sampled.
REQ-021 After reset release, history SHALL start at 0, so a din held at 1 through reset SHALL produce exactly one rise pulse (and a flag pulse in mode 0 or 2) SYNC_STAGES+1 edges after release.
REQ-022 Outputs SHALL be low during and immediately after reset until a detected edge occurs.

Verification
REQ-023 Rising edge, defaults, 20 ns clock: reset, then din 0->1 held for 5 cycles -> rise=1 and flag=1 for exactly one cycle, two edges after din is sampled high; fall=0 throughout.
REQ-024 Falling edge, EDGE_MODE=0: din 1->0 -> fall pulses once, flag stays 0; with EDGE_MODE=1, flag pulses once.
REQ-025 Toggle pattern 0,1,0,1,0,1 with a 25-30 ns spacing, defaults -> five flag pulses, alternating rise/fall, each exactly 1 cycle, order preserved.
REQ-026 Reset mid-pulse: assert rst_n=1 on the cycle flag would go high -> flag stays 0; the next din edge after release is detected normally.
REQ-027 din held at 1 across reset -> exactly one rise/flag pulse 3 edges after release (SYNC_STAGES=2); no further pulses while din stays 1.
REQ-028 SYNC_STAGES=1 -> latency is 1 edge; a sub-period glitch that no clock edge samples -> no pulse.
